// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, icodes, register IDs and the
// writeback state type used by the register-file slice.
package y86_pkg;

  typedef enum logic [2:0] {
    STAT_BUB = 3'd0,
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } wb_state_t;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] R_RAX = 4'h0;
  localparam logic [3:0] R_RCX = 4'h1;
  localparam logic [3:0] R_RDX = 4'h2;
  localparam logic [3:0] R_RBX = 4'h3;
  localparam logic [3:0] R_RSP = 4'h4;
  localparam logic [3:0] R_RBP = 4'h5;
  localparam logic [3:0] R_RSI = 4'h6;
  localparam logic [3:0] R_RDI = 4'h7;
  localparam logic [3:0] R_R8  = 4'h8;
  localparam logic [3:0] R_R9  = 4'h9;
  localparam logic [3:0] R_R10 = 4'hA;
  localparam logic [3:0] R_R11 = 4'hB;
  localparam logic [3:0] R_R12 = 4'hC;
  localparam logic [3:0] R_R13 = 4'hD;
  localparam logic [3:0] R_R14 = 4'hE;

  // Map a non-AOK, non-bubble W status onto the status that gets latched;
  // codes outside the defined set are reported as an invalid instruction.
  function automatic stat_t fault_stat(input logic [2:0] s);
    case (s)
      STAT_HLT: fault_stat = STAT_HLT;
      STAT_ADR: fault_stat = STAT_ADR;
      default:  fault_stat = STAT_INS;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Architectural register array: two asynchronous read ports and two
// synchronous write ports, with port M winning on an address collision.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int NREG = 15,
  parameter int DW   = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_e,
  input  logic [3:0]    addr_e,
  input  logic [DW-1:0] data_e,
  input  logic          we_m,
  input  logic [3:0]    addr_m,
  input  logic [DW-1:0] data_m,
  input  logic [3:0]    raddr_a,
  input  logic [3:0]    raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  localparam logic [3:0] NREG_ID = 4'(NREG);

  logic [DW-1:0] regs [NREG];

  // The M write is issued last so it overrides E when both hit the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (we_e && (addr_e < NREG_ID)) begin
        regs[addr_e] <= data_e;
      end
      if (we_m && (addr_m < NREG_ID)) begin
        regs[addr_m] <= data_m;
      end
    end
  end

  assign rdata_a = (raddr_a < NREG_ID) ? regs[raddr_a] : '0;
  assign rdata_b = (raddr_b < NREG_ID) ? regs[raddr_b] : '0;

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 writeback stage: commits W into the register file, tracks the
// processor status, counts retired instructions and freezes on a fault.
module wb_regfile
  import y86_pkg::*;
#(
  parameter int NREG = 15,
  parameter int DW   = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    w_stat,
  input  logic [3:0]    w_icode,
  input  logic [3:0]    w_dstE,
  input  logic [3:0]    w_dstM,
  input  logic [DW-1:0] w_valE,
  input  logic [DW-1:0] w_valM,
  input  logic [3:0]    d_srcA,
  input  logic [3:0]    d_srcB,
  output logic [DW-1:0] d_rvalA,
  output logic [DW-1:0] d_rvalB,
  output logic [2:0]    proc_stat,
  output logic          halted,
  output logic [63:0]   retired
);

  wb_state_t   state, state_n;
  logic [2:0]  stat_n;
  logic [63:0] retired_n;
  logic        we_e, we_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      proc_stat <= STAT_AOK;
      retired   <= '0;
    end else begin
      state     <= state_n;
      proc_stat <= stat_n;
      retired   <= retired_n;
    end
  end

  // In HALTED every default holds, which is what freezes architectural state.
  always_comb begin
    state_n   = state;
    stat_n    = proc_stat;
    retired_n = retired;
    we_e      = 1'b0;
    we_m      = 1'b0;
    if (state == ST_RUN) begin
      case (w_stat)
        STAT_BUB: ;
        STAT_AOK: begin
          we_e      = (w_dstE != RNONE);
          we_m      = (w_dstM != RNONE);
          retired_n = retired + 64'd1;
        end
        default: begin
          stat_n  = fault_stat(w_stat);
          state_n = ST_HALTED;
          if (w_stat == STAT_HLT) begin
            retired_n = retired + 64'd1;
          end
        end
      endcase
    end
  end

  assign halted = (state == ST_HALTED);

  regfile_2r2w #(
    .NREG (NREG),
    .DW   (DW)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .we_e    (we_e),
    .addr_e  (w_dstE),
    .data_e  (w_valE),
    .we_m    (we_m),
    .addr_m  (w_dstM),
    .data_m  (w_valM),
    .raddr_a (d_srcA),
    .raddr_b (d_srcB),
    .rdata_a (d_rvalA),
    .rdata_b (d_rvalB)
  );

  // A halt instruction reaching writeback must carry HLT status, never AOK.
  halt_icode_chk: assert property (@(posedge clk) disable iff (rst)
    !(state == ST_RUN && w_stat == STAT_AOK && w_icode == I_HALT));

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// commits compared against an architectural model of the writeback stage.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  w_stat;
  logic [3:0]  w_icode;
  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;
  logic [63:0] w_valE;
  logic [63:0] w_valM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [2:0]  proc_stat;
  logic        halted;
  logic [63:0] retired;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [15];
  logic [2:0]  m_stat;
  logic        m_halted;
  logic [63:0] m_retired;

  always #5 clk = ~clk;

  wb_regfile #(.NREG(15), .DW(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_stat    (w_stat),
    .w_icode   (w_icode),
    .w_dstE    (w_dstE),
    .w_dstM    (w_dstM),
    .w_valE    (w_valE),
    .w_valM    (w_valM),
    .d_srcA    (d_srcA),
    .d_srcB    (d_srcB),
    .d_rvalA   (d_rvalA),
    .d_rvalB   (d_rvalB),
    .proc_stat (proc_stat),
    .halted    (halted),
    .retired   (retired)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expRead(input int id);
    return (id >= 0 && id < 15) ? m_regs[id] : 64'd0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
    m_stat    = 3'd1;
    m_halted  = 1'b0;
    m_retired = 64'd0;
  endtask

  // Architectural effect of one instruction reaching writeback.
  task automatic modelStep(input logic [2:0] st, input logic [3:0] dE, input logic [3:0] dM,
                           input logic [63:0] vE, input logic [63:0] vM);
    if (m_halted) return;
    if (st == 3'd0) return;
    if (st == 3'd1) begin
      if (dE != 4'hF) m_regs[dE] = vE;
      if (dM != 4'hF) m_regs[dM] = vM;
      m_retired = m_retired + 64'd1;
      return;
    end
    m_halted = 1'b1;
    if (st == 3'd2) begin
      m_stat    = 3'd2;
      m_retired = m_retired + 64'd1;
    end else if (st == 3'd3) begin
      m_stat = 3'd3;
    end else begin
      m_stat = 3'd4;
    end
  endtask

  task automatic idleW();
    w_stat  = 3'd0;
    w_icode = 4'h1;
    w_dstE  = 4'hF;
    w_dstM  = 4'hF;
    w_valE  = 64'd0;
    w_valM  = 64'd0;
  endtask

  task automatic applyStimulus(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] dE,
                               input logic [3:0] dM, input logic [63:0] vE, input logic [63:0] vM);
    @(negedge clk);
    w_stat  = st;
    w_icode = ic;
    w_dstE  = dE;
    w_dstM  = dM;
    w_valE  = vE;
    w_valM  = vM;
    @(posedge clk);
    modelStep(st, dE, dM, vE, vM);
    #1;
    idleW();
  endtask

  task automatic doReset(input bit with_commit);
    @(negedge clk);
    rst = 1'b1;
    if (with_commit) begin
      w_stat  = 3'd1;
      w_icode = 4'h3;
      w_dstE  = 4'h5;
      w_valE  = 64'hDEAD_BEEF_0000_0005;
    end
    @(posedge clk);
    modelReset();
    #1;
    rst = 1'b0;
    idleW();
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".proc_stat"}, {61'd0, proc_stat}, {61'd0, m_stat});
    check({tag, ".halted"}, {63'd0, halted}, {63'd0, m_halted});
    check({tag, ".retired"}, retired, m_retired);
    for (int i = 0; i < 16; i++) begin
      d_srcA = 4'(i);
      d_srcB = 4'(15 - i);
      #1;
      check($sformatf("%s.rvalA[%0d]", tag, i), d_rvalA, expRead(i));
      check($sformatf("%s.rvalB[%0d]", tag, 15 - i), d_rvalB, expRead(15 - i));
    end
  endtask

  task automatic randomCommit();
    logic [2:0]  st;
    logic [3:0]  dE, dM;
    st = ($urandom_range(9, 0) == 0) ? 3'd0 : 3'd1;
    dE = ($urandom_range(4, 0) == 0) ? 4'hF : 4'($urandom_range(14, 0));
    dM = ($urandom_range(2, 0) == 0) ? 4'hF : 4'($urandom_range(14, 0));
    if ($urandom_range(7, 0) == 0) dM = dE;
    applyStimulus(st, 4'($urandom_range(11, 1)), dE, dM, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  initial begin
    rst    = 1'b0;
    d_srcA = 4'hF;
    d_srcB = 4'hF;
    idleW();
    modelReset();

    doReset(1'b0);
    checkOutput("reset");

    @(negedge clk);
    w_stat  = 3'd1;
    w_icode = 4'h3;
    w_dstE  = 4'h0;
    w_valE  = 64'h1234;
    d_srcA  = 4'h0;
    #1;
    check("no_bypass", d_rvalA, expRead(0));
    @(posedge clk);
    modelStep(3'd1, 4'h0, 4'hF, 64'h1234, 64'd0);
    #1;
    idleW();
    checkOutput("write_rax");

    applyStimulus(3'd1, 4'hB, 4'h4, 4'h4, 64'h100, 64'h200);
    checkOutput("popq_rsp");

    applyStimulus(3'd0, 4'h6, 4'h1, 4'hF, 64'hFF, 64'd0);
    checkOutput("bubble");

    applyStimulus(3'd1, 4'h6, 4'hF, 4'hF, 64'h55, 64'h66);
    checkOutput("rnone_write");

    for (int n = 0; n < 150; n++) begin
      randomCommit();
      if (n % 25 == 24) checkOutput($sformatf("rand%0d", n));
    end

    applyStimulus(3'd3, 4'h5, 4'hF, 4'h2, 64'd0, 64'd5);
    applyStimulus(3'd1, 4'h3, 4'h3, 4'hF, 64'd7, 64'd0);
    checkOutput("adr_freeze");

    doReset(1'b0);
    for (int n = 0; n < 20; n++) randomCommit();
    applyStimulus(3'd2, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
    checkOutput("hlt");
    applyStimulus(3'd1, 4'h3, 4'h6, 4'h7, 64'h77, 64'h88);
    checkOutput("hlt_frozen");

    doReset(1'b0);
    checkOutput("reset_from_halted");

    for (int n = 0; n < 10; n++) randomCommit();
    doReset(1'b1);
    checkOutput("reset_priority");

    for (int n = 0; n < 30; n++) randomCommit();
    applyStimulus(3'($urandom_range(7, 5)), 4'hF, 4'h1, 4'h2, 64'h11, 64'h22);
    checkOutput("undef_stat");
    applyStimulus(3'd4, 4'hF, 4'h3, 4'hF, 64'h33, 64'd0);
    checkOutput("ins_after_halt");

    doReset(1'b0);
    applyStimulus(3'd4, 4'hF, 4'h8, 4'h9, 64'h1, 64'h2);
    checkOutput("ins");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
